// File: rtl/tff_ctrl_pkg.sv
// Shared types for the TFF counter controller: FSM state encoding and direction codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic UP = 1'b1;
    localparam logic DN = 1'b0;

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Command/load/status bundle between a sequencing master and the TFF counter controller.
// Latency: n/a (wiring only).
// Backpressure: load_valid is held by the master until load_ready is seen high.
interface tff_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             up_dn;
    logic             one_shot;
    logic [WIDTH-1:0] mod_lim;
    logic             load_valid;
    logic [WIDTH-1:0] load_val;
    logic             load_ready;
    logic [WIDTH-1:0] t_out;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, up_dn, one_shot, mod_lim, load_valid, load_val,
        input  load_ready, t_out, count, busy, tc, done
    );

    modport slave (
        input  start, stop, up_dn, one_shot, mod_lim, load_valid, load_val,
        output load_ready, t_out, count, busy, tc, done
    );
endinterface

// File: rtl/tff.sv
// Single toggle flip-flop: q inverts on each core_clk edge where t is high.
// Latency: one edge from t to q.
// Backpressure: none.
module tff (
    input  logic core_clk,
    input  logic arst_n,
    input  logic t,
    output logic q
);
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end
endmodule

// File: rtl/tff_bank.sv
// Bank of WIDTH toggle flip-flops whose q outputs form the counter value.
// Latency: one edge from t to q.
// Backpressure: none; every toggle vector is applied.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);
    logic arst_n;

    assign arst_n = ~rst;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        tff u_tff (
            .core_clk (clk),
            .arst_n   (arst_n),
            .t        (t[i]),
            .q        (q[i])
        );
    end
endmodule

// File: rtl/tff_count_ctrl.sv
// Drives a TFF bank as a programmable-modulus up/down counter with start/stop, load and one-shot.
// Latency: start at edge k gives the first step at edge k+1; a load lands one edge after handshake.
// Backpressure: load_ready is low in RUN, so loads are only taken in IDLE or DONE.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    tff_count_ctrl_if.slave   bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] lim_q;
    logic             dir_q;
    logic             os_q;
    logic             tc_q;
    logic             tc_d;
    logic             latch_en;
    logic             load_rdy;
    logic             load_fire;
    logic             wrap;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] t_vec;

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk (clk),
        .rst (rst),
        .t   (t_vec),
        .q   (cnt)
    );

    // Out-of-range counts (above lim) take the wrap branch in either direction.
    always_comb begin
        wrap = 1'b0;
        nxt  = cnt;
        if (dir_q == UP) begin
            wrap = (cnt >= lim_q);
            nxt  = wrap ? '0 : cnt + ONE;
        end else begin
            wrap = (cnt == '0) || (cnt > lim_q);
            nxt  = wrap ? lim_q : cnt - ONE;
        end
    end

    assign load_rdy  = (state_q != RUN);
    assign load_fire = load_rdy & bus.load_valid;

    always_comb begin
        state_d  = state_q;
        t_vec    = '0;
        tc_d     = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else begin
                    t_vec = cnt ^ nxt;
                    tc_d  = wrap;
                    if (wrap && os_q) begin
                        state_d = DONE;
                    end
                end
            end
            IDLE, DONE: begin
                // A load in the same cycle as start lands first; stepping begins next cycle.
                if (load_fire) begin
                    t_vec = cnt ^ bus.load_val;
                end
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    state_d  = RUN;
                    latch_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lim_q <= '0;
            dir_q <= UP;
            os_q  <= 1'b0;
        end else if (latch_en) begin
            lim_q <= bus.mod_lim;
            dir_q <= bus.up_dn;
            os_q  <= bus.one_shot;
        end
    end

    assign bus.load_ready = load_rdy;
    assign bus.t_out      = t_vec;
    assign bus.count      = cnt;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.tc         = tc_q;
endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for a bank of T flip-flops. Drives the per-bit toggle enables so the bank behaves as a programmable-modulus up/down counter with start/stop control, a load handshake, terminal-count pulse and one-shot mode. Sits beside the counter datapath. It is the only source of the bank's T inputs, so all counter state changes go through this block.

## Interface
- WIDTH, 4: counter width, and the number of TFF stages.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled each cycle; begins counting from IDLE or DONE.
- stop  in  1  level; halts counting and returns to IDLE.
- up_dn  in  1  1 = count up, 0 = count down; latched when a start is accepted.
- one_shot  in  1  1 = stop at first wrap; latched when a start is accepted.
- mod_lim  in  WIDTH  terminal value, so the count range is 0..mod_lim; latched when a start is accepted.
- load_valid  in  1  load request.
- load_val  in  WIDTH  value to load.
- load_ready  out  1  load acceptance; high in IDLE and DONE.
- t_out  out  WIDTH  toggle vector applied to the bank this cycle.
- count  out  WIDTH  bank state (the TFF q outputs).
- busy  out  1  high in RUN.
- tc  out  1  one-cycle pulse, registered, coincident with the wrapped count value.
- done  out  1  high in DONE.

## Operation
- States: IDLE, RUN, DONE.
- Next-count value, called nxt:
  - Up: nxt = (count >= lim) ? 0 : count+1.
  - Down: nxt = (count == 0 || count > lim) ? lim : count-1.
- Toggle vector: t_out = count ^ nxt in RUN; t_out = count ^ load_val on a load; otherwise t_out = 0.
- A wrap is any step that takes the 0/lim branch.
- IDLE:
  - start & !stop → RUN; latch lim, dir and one_shot.
  - load_valid → load.
  - stop → stay in IDLE.
- RUN:
  - Step every cycle.
  - stop → IDLE with count frozen; stop takes priority over stepping.
  - start is ignored.
  - On a wrap with one_shot=1 → DONE; the wrap step is still applied.
- DONE:
  - count holds.
  - start → RUN with fresh latches.
  - load is permitted.
  - stop → IDLE.
- Load: load_valid & load_ready transfers load_val into count at the next edge. No clamping is applied; out-of-range values are corrected by the next step.
- start and load_valid in the same cycle from IDLE or DONE: the load is applied first. Counting from the loaded value begins the following cycle, and the state moves to RUN.
- mod_lim = 0: count stays 0, and tc pulses every RUN cycle.
- Reset mid-run: all state clears immediately. No tc or done pulse is generated.

## Timing
- Values on reset: count=0, state IDLE, tc=0, done=0, busy=0, load_ready=1, t_out=0.
- Command latency: a start accepted at edge k gives the first step on count at edge k+1.
- Load latency: count equals load_val one edge after the handshake.
- busy and done are decoded from registered state, with no combinational path from inputs.
- load_ready is decoded from state only.
- t_out is combinational from state, inputs and count. It must settle within one cycle.
- tc is registered and asserted for exactly one cycle per wrap. In one-shot mode it coincides with the first cycle of done.

## Structure
- Package tff_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DONE) and its 2-bit encoding;
  - the direction localparams UP=1 and DN=0.
- Sub-module tff_bank:
  - WIDTH instances of the team TFF, with q concatenated to count.
  - Its reset polarity is adapted internally from rst.
- The controller holds the FSM, the latch registers, the nxt/t_out logic and the tc register.
- Target size is about 150–250 lines.

## Test plan
- Up count: WIDTH=4, mod_lim=9, up, one_shot=0, start for 1 cycle.
  - count runs 0..9, 0, 1, …
  - tc pulses when count shows 0, every 10 cycles.
- Down count from load: load_val=3 accepted in IDLE, then start with up_dn=0 and mod_lim=5.
  - count runs 3, 2, 1, 0, 5, 4, …
  - tc coincides with count=5.
- One-shot: mod_lim=2, up, one_shot=1.
  - count runs 0, 1, 2, 0, then holds at 0.
  - done=1 and tc=1 in the same cycle; busy drops.
  - A subsequent start resumes counting.
- Priorities:
  - start and stop together in IDLE → stays IDLE.
  - stop in RUN at count=6 → count holds 6, load_ready=1.
  - load_valid in RUN is ignored (load_ready=0).
- Out-of-range load: load_val=14 with mod_lim=9, then start up → next count is 0 with a tc pulse.
- Reset mid-run: assert rst at count=7.
  - count, tc, busy and done go to 0 asynchronously.
  - After release, the controller is IDLE with load_ready=1.
